icb_apb_bridge: RTL
===================

// Module: icb_apb_bridge
// PURPOSE
//   Converts single ICB commands into APB transfers and returns each APB completion as one ICB response.
//   Upstream is an ICB master (core or interconnect port); downstream is an APB peripheral segment.
//   Handles one transaction at a time, with an optional PREADY timeout so a dead peripheral cannot hang the bus.
// PARAMETERS
//   ADDR_WIDTH      32   address width, shared by ICB and APB (1~32)
//   DATA_WIDTH      32   data width, shared by ICB and APB (8 | 16 | 32)
//   TIMEOUT_CYCLES  256  ACCESS cycles without pready before forced error; 0 = timeout disabled
// PORTS
//   clk                 in   1             clock
//   rst_n               in   1             asynchronous active-low reset
//   s_icb_cmd_addr      in   ADDR_WIDTH    command address
//   s_icb_cmd_read      in   1             1 = read, 0 = write
//   s_icb_cmd_wdata     in   DATA_WIDTH    write data
//   s_icb_cmd_wmask     in   DATA_WIDTH/8  write byte mask
//   s_icb_cmd_valid     in   1             command valid
//   s_icb_cmd_ready     out  1             command ready
//   s_icb_rsp_rdata     out  DATA_WIDTH    read data (0 for writes)
//   s_icb_rsp_err       out  1             response error
//   s_icb_rsp_valid     out  1             response valid
//   s_icb_rsp_ready     in   1             response ready
//   m_apb_paddr         out  ADDR_WIDTH    APB address
//   m_apb_pprot         out  3             fixed 3'b000
//   m_apb_pselx         out  1             APB select
//   m_apb_penable       out  1             APB enable
//   m_apb_pwrite        out  1             APB write
//   m_apb_pwdata        out  DATA_WIDTH    APB write data
//   m_apb_pstrb         out  DATA_WIDTH/8  write strobe (0 on reads)
//   m_apb_pready        in   1             APB ready
//   m_apb_prdata        in   DATA_WIDTH    APB read data
//   m_apb_pslverr       in   1             APB slave error
// BEHAVIOUR
//   Interface: one clock, clk; reset rst_n is asynchronous, active-low. All outputs are registered or decoded from the state register.
//   Reset: state IDLE; pselx, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid, rsp_err, rsp_rdata = 0.
//     cmd_ready = 1 (IDLE decode). Upstream must not assert cmd_valid while rst_n is low.
//   FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE:
//     IDLE:   cmd_ready=1. On cmd_valid, latch paddr=addr, pwrite=~read, pwdata=wdata, pstrb=read?0:wmask; go to SETUP.
//     SETUP:  pselx=1, penable=0, one cycle only; go to ACCESS.
//     ACCESS: pselx=1, penable=1; hold all APB outputs stable. Clear the timeout counter on entry.
//       When pready=1: rsp_rdata = read ? prdata : 0; rsp_err = pslverr; drop pselx and penable; go to RESP.
//       Timeout: TIMEOUT_CYCLES>0 and counter reaches TIMEOUT_CYCLES-1 with pready=0:
//         rsp_err = 1, rsp_rdata = 0; drop pselx and penable; go to RESP.
//       pready wins if it coincides with the timeout cycle.
//     RESP:   rsp_valid=1, rsp_rdata and rsp_err held stable. On rsp_ready, go to IDLE with rsp_valid=0 next cycle.
//   cmd_ready is 0 in SETUP, ACCESS and RESP. No new command is accepted until the response has been handed off.
//   Latency: command accepted at edge N, SETUP in cycle N..N+1, ACCESS from edge N+1.
//     With pready=1 in the first ACCESS cycle, rsp_valid rises at edge N+2.
//     Minimum command-to-command period is 4 cycles.
//   Between transfers: pselx=0, penable=0; paddr, pwdata, pstrb, pwrite keep their last values.
//   Timeout counter width is clog2(TIMEOUT_CYCLES)+1 and saturates; it never wraps.
//   Reset mid-transfer: FSM returns to IDLE asynchronously; pselx, penable, rsp_valid drop immediately.
//     The in-flight transaction is dropped with no response.
//   X-safety: prdata and pslverr are sampled only when state==ACCESS and pready==1.
// TESTING
//   1. Write addr=0x40, wdata=0xDEADBEEF, wmask=4'b0011, pready=1 immediately
//      -> SETUP then ACCESS with pstrb=4'b0011, pwrite=1; rsp_valid at +2 edges, err=0, rdata=0.
//   2. Read addr=0x44 with pready held low 3 ACCESS cycles, prdata=0x12345678
//      -> penable high for 4 cycles, APB outputs stable; rsp_rdata=0x12345678, pstrb=0.
//   3. Read with pslverr=1 at pready, then rsp_ready low 5 cycles
//      -> rsp_err=1 held with rsp_valid for 5 cycles; cmd_ready=0 throughout.
//   4. TIMEOUT_CYCLES=8, pready never asserted
//      -> exactly 8 ACCESS cycles, then pselx=0, rsp_err=1, rsp_rdata=0.
//   5. rst_n pulsed low during ACCESS
//      -> pselx, penable, rsp_valid = 0 asynchronously, cmd_ready=1 after release, no stray response.
//   6. Back-to-back writes with cmd_valid and rsp_ready held high
//      -> one accept every 4 cycles, pselx low for >=1 cycle between transfers.

Source files
------------

// File: rtl/icb_apb_bridge_if.sv
// Bus bundle between an ICB master and an APB completer, with the bridge in the middle.
// The interface has two modports:
//   slave  : the bridge's view. It receives ICB commands and drives the APB request.
//   master : the surrounding environment's view. This is the ICB master together with
//            the APB peripheral segment, so every direction is the mirror of "slave".
// Signals:
//   s_icb_cmd_*  : ICB command channel (addr, read, wdata, wmask, valid / ready)
//   s_icb_rsp_*  : ICB response channel (rdata, err, valid / ready)
//   m_apb_*      : APB request (paddr, pprot, pselx, penable, pwrite, pwdata, pstrb)
//                  and APB completion (pready, prdata, pslverr)
interface icb_apb_bridge_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   s_icb_cmd_addr;
   logic                    s_icb_cmd_read;
   logic [DATA_WIDTH-1:0]   s_icb_cmd_wdata;
   logic [DATA_WIDTH/8-1:0] s_icb_cmd_wmask;
   logic                    s_icb_cmd_valid;
   logic                    s_icb_cmd_ready;
   logic [DATA_WIDTH-1:0]   s_icb_rsp_rdata;
   logic                    s_icb_rsp_err;
   logic                    s_icb_rsp_valid;
   logic                    s_icb_rsp_ready;
   logic [ADDR_WIDTH-1:0]   m_apb_paddr;
   logic [2:0]              m_apb_pprot;
   logic                    m_apb_pselx;
   logic                    m_apb_penable;
   logic                    m_apb_pwrite;
   logic [DATA_WIDTH-1:0]   m_apb_pwdata;
   logic [DATA_WIDTH/8-1:0] m_apb_pstrb;
   logic                    m_apb_pready;
   logic [DATA_WIDTH-1:0]   m_apb_prdata;
   logic                    m_apb_pslverr;

   modport slave (
      input  s_icb_cmd_addr, s_icb_cmd_read, s_icb_cmd_wdata, s_icb_cmd_wmask, s_icb_cmd_valid,
      output s_icb_cmd_ready,
      output s_icb_rsp_rdata, s_icb_rsp_err, s_icb_rsp_valid,
      input  s_icb_rsp_ready,
      output m_apb_paddr, m_apb_pprot, m_apb_pselx, m_apb_penable, m_apb_pwrite,
      output m_apb_pwdata, m_apb_pstrb,
      input  m_apb_pready, m_apb_prdata, m_apb_pslverr
   );

   modport master (
      output s_icb_cmd_addr, s_icb_cmd_read, s_icb_cmd_wdata, s_icb_cmd_wmask, s_icb_cmd_valid,
      input  s_icb_cmd_ready,
      input  s_icb_rsp_rdata, s_icb_rsp_err, s_icb_rsp_valid,
      output s_icb_rsp_ready,
      input  m_apb_paddr, m_apb_pprot, m_apb_pselx, m_apb_penable, m_apb_pwrite,
      input  m_apb_pwdata, m_apb_pstrb,
      output m_apb_pready, m_apb_prdata, m_apb_pslverr
   );
endinterface

// File: rtl/icb_apb_bridge.sv
// ICB-to-APB bridge. It takes one ICB command at a time, runs it as one APB transfer,
// and returns the APB completion as one ICB response. An optional PREADY timeout stops a
// dead peripheral from hanging the bus.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : icb_apb_bridge_if.slave, which carries the ICB command/response and APB signals
// FSM states:
//   state  | meaning
//   IDLE   | cmd_ready=1; a valid command is latched onto the APB request registers
//   SETUP  | APB setup phase (pselx=1, penable=0), lasts exactly one cycle
//   ACCESS | APB access phase (pselx=1, penable=1); wait for pready or for the timeout
//   RESP   | rsp_valid=1; hold the response until rsp_ready
module icb_apb_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic             clk,
   input  logic             rst_n,
   icb_apb_bridge_if.slave  bus
);
   localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST =
      (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   logic [1:0]              state;
   logic [CNT_WIDTH-1:0]    wait_cnt;
   logic [ADDR_WIDTH-1:0]   paddr;
   logic                    pwrite;
   logic [DATA_WIDTH-1:0]   pwdata;
   logic [DATA_WIDTH/8-1:0] pstrb;
   logic [DATA_WIDTH-1:0]   rsp_rdata;
   logic                    rsp_err;
   logic                    timeout_hit;

   // A pready that arrives in the same cycle as the timeout takes priority over it.
   assign timeout_hit = (TIMEOUT_CYCLES > 0) && (wait_cnt == CNT_LAST) && !bus.m_apb_pready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         wait_cnt  <= '0;
         paddr     <= '0;
         pwrite    <= 1'b0;
         pwdata    <= '0;
         pstrb     <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.s_icb_cmd_valid) begin
                  paddr  <= bus.s_icb_cmd_addr;
                  pwrite <= !bus.s_icb_cmd_read;
                  pwdata <= bus.s_icb_cmd_wdata;
                  pstrb  <= bus.s_icb_cmd_read ? '0 : bus.s_icb_cmd_wmask;
                  state  <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               wait_cnt <= '0;
               state    <= ST_ACCESS;
            end
            ST_ACCESS: begin
               // prdata and pslverr are read only here, so X on an idle bus never leaks in.
               if (bus.m_apb_pready) begin
                  rsp_rdata <= pwrite ? '0 : bus.m_apb_prdata;
                  rsp_err   <= bus.m_apb_pslverr;
                  state     <= ST_RESP;
               end else if (timeout_hit) begin
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b1;
                  state     <= ST_RESP;
               end else if (wait_cnt != '1) begin
                  wait_cnt <= wait_cnt + CNT_WIDTH'(1);
               end
            end
            ST_RESP: begin
               if (bus.s_icb_rsp_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Handshake and select outputs are decoded from the state register. Reset therefore
   // drops them at once, without waiting for a clock edge.
   assign bus.s_icb_cmd_ready = (state == ST_IDLE);
   assign bus.s_icb_rsp_valid = (state == ST_RESP);
   assign bus.s_icb_rsp_rdata = rsp_rdata;
   assign bus.s_icb_rsp_err   = rsp_err;
   assign bus.m_apb_pselx     = (state == ST_SETUP) || (state == ST_ACCESS);
   assign bus.m_apb_penable   = (state == ST_ACCESS);
   assign bus.m_apb_paddr     = paddr;
   assign bus.m_apb_pwrite    = pwrite;
   assign bus.m_apb_pwdata    = pwdata;
   assign bus.m_apb_pstrb     = pstrb;
   assign bus.m_apb_pprot     = 3'b000;
endmodule
